fifo_uart_tx: RTL and testbench

Serial transmit stage that drains the 8-bit FIFO on its read side. It issues single-cycle read strobes, captures the byte returned with the FIFO's `valid` flag, and shifts it out LSB-first as an asynchronous serial frame: start bit, 8 data bits, optional parity bit, stop bit. It sits directly downstream of the FIFO, which runs in NORMAL (non-FWFT) read mode, and drives the external serial line.

---
 rtl/fifo_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: serial transmit stage that drains an 8-bit FIFO in normal
// (non-FWFT) read mode. It issues a one-cycle read strobe, captures the byte
// returned with fifo_valid, and shifts it out LSB-first as
// start + 8 data + [parity] + stop.
//
// Build option: define UART_PARITY_EN to insert an even-parity bit after the
// data bits (11-bit frame). When it is undefined the frame is 10 bits.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   tx_en       allow fetching new bytes (not an abort)
//   fifo_data   FIFO data_out
//   fifo_empty  FIFO empty flag, sampled only in IDLE
//   fifo_valid  FIFO valid, expected the cycle after the read strobe
//   fifo_rd_en  registered single-cycle read strobe
//   tx          serial line, idles high
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse when the stop bit completes
//   rd_err      one-cycle pulse when fifo_valid is missing after a read
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  input  logic       fifo_valid,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       rd_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             tx_q, tx_d;
  logic             rd_q, rd_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic bit_end;
  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Baud counter only runs while a serial bit is on the line.
    if (state_q == S_START || state_q == S_DATA || state_q == S_STOP
`ifdef UART_PARITY_EN
        || state_q == S_PARITY
`endif
       ) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !fifo_empty) begin
          state_d = S_FETCH;
          rd_d    = 1'b1;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (fifo_valid) begin
          sh_d    = fifo_data;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = sh_q[0];
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
`ifdef UART_PARITY_EN
            tx_d    = ^sh_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign fifo_rd_en = rd_q;
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign rd_err     = err_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int CPB = 4;
  localparam int FL  = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n, tx_en;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_valid = 1'b0;
  logic       fifo_rd_en, tx, busy, frame_done, rd_err;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_valid(fifo_valid), .fifo_rd_en(fifo_rd_en),
    .tx(tx), .busy(busy), .frame_done(frame_done), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         gap;   // expected idle cycles before this frame, -1 = unchecked
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fq[$];
  logic       suppress = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Normal-mode FIFO model: data and valid appear the cycle after a read.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0 && !suppress) begin
      fifo_data  <= fq.pop_front();
      fifo_valid <= 1'b1;
    end else begin
      fifo_valid <= 1'b0;
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Monitor: decodes the serial line and checks it against the scoreboard.
  int         cyc = 0, last_done = 0, gap = 0, off = 0, rd_cnt = 0;
  logic       in_frame = 1'b0, prev_tx = 1'b1, prev_rd = 1'b0;
  logic       glitch, sb, stopb, parb, done_early;
  logic [7:0] rx;

  always @(negedge clk) begin
    cyc++;
    if (fifo_rd_en) begin
      rd_cnt++;
      chk("rd_en_not_consecutive", prev_rd, 1'b0);
    end
    prev_rd = fifo_rd_en;
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (prev_tx && !tx) begin
        in_frame = 1'b1;
        off      = 0;
        glitch   = 1'b0;
        gap      = cyc - last_done;
      end
    end else begin
      off++;
      if (off < FL && (off % CPB) != 0 && tx !== prev_tx) glitch = 1'b1;
      if ((off % CPB) == CPB / 2) begin
        int bn;
        bn = off / CPB;
        if (bn == 0) sb = tx;
        else if (bn <= 8) rx[bn-1] = tx;
        else if (bn == NBITS - 1) stopb = tx;
        else parb = tx;
      end
      if (off == FL - 1) done_early = frame_done;
      if (off == FL) begin
        in_frame  = 1'b0;
        last_done = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {24'h0, rx}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame_data", {24'h0, rx}, {24'h0, e.d});
          chk("start_bit", sb, 1'b0);
          chk("stop_bit", stopb, 1'b1);
          chk("bit_width", glitch, 1'b0);
          chk("frame_done_timing", {done_early, frame_done}, 2'b01);
          chk("idle_after_frame", tx, 1'b1);
`ifdef UART_PARITY_EN
          chk("parity_bit", parb, ^e.d);
`endif
          if (e.gap >= 0) chk("frame_gap", gap, e.gap);
        end
      end
    end
    prev_tx = tx;
  end

  task automatic wait_exp(input int bound, input string nm);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout with %0d frames outstanding, required 0", nm, exp_q.size());
    end
  endtask

  task automatic wait_rd(input int bound, input string nm);
    int i;
    for (i = 0; i < bound && !fifo_rd_en; i++) @(negedge clk);
    chk(nm, fifo_rd_en, 1'b1);
  endtask

  initial begin
    int   r0;
    logic tx_low;
    rst_n = 1'b0;
    tx_en = 1'b1;

    // Reset held with a byte waiting and tx_en high.
    fq.push_back(8'hA5);
    exp_q.push_back('{8'hA5, -1});
    repeat (5) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_rd_err", rd_err, 1'b0);

    // Single byte 0xA5 after reset release.
    r0    = rd_cnt;
    rst_n = 1'b1;
    wait_exp(200, "frame_a5");
    chk("a5_rd_pulses", rd_cnt - r0, 1);
    repeat (3) @(negedge clk);

    // Missing valid after the read.
    suppress = 1'b1;
    tx_low   = 1'b0;
    fq.push_back(8'h3C);
    for (int i = 0; i < 20 && !rd_err; i++) begin
      @(negedge clk);
      if (!tx) tx_low = 1'b1;
    end
    chk("rd_err_pulse", rd_err, 1'b1);
    chk("rd_err_busy", busy, 1'b0);
    tx_en = 1'b0;
    chk("rd_err_tx_high", tx_low, 1'b0);
    @(negedge clk);
    chk("rd_err_one_cycle", rd_err, 1'b0);
    chk("rd_err_tx_after", tx, 1'b1);
    fq.delete();
    suppress = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back 0x00 then 0xFF.
    tx_en = 1'b1;
    r0    = rd_cnt;
    exp_q.push_back('{8'h00, -1});
    exp_q.push_back('{8'hFF, 3});
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    wait_exp(300, "frames_b2b");
    chk("b2b_rd_pulses", rd_cnt - r0, 2);
    repeat (3) @(negedge clk);

    // tx_en low with data waiting: no reads.
    tx_en = 1'b0;
    fq.push_back(8'h11);
    r0 = rd_cnt;
    repeat (50) @(negedge clk);
    chk("txen_off_no_read", rd_cnt - r0, 0);
    chk("txen_off_busy", busy, 1'b0);

    // tx_en dropped during DATA: frame finishes, no further read.
    exp_q.push_back('{8'h11, -1});
    fq.push_back(8'h22);
    tx_en = 1'b1;
    wait_rd(20, "txen_drop_rd");
    repeat (15) @(negedge clk);
    chk("txen_drop_busy", busy, 1'b1);
    tx_en = 1'b0;
    wait_exp(100, "frame_txen_drop");
    repeat (30) @(negedge clk);
    chk("txen_drop_rd_pulses", rd_cnt - r0, 1);
    fq.delete();
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of 0xC3 (bit 3 is 0).
    tx_en = 1'b1;
    fq.push_back(8'hC3);
    wait_rd(20, "midrst_rd");
    repeat (19) @(negedge clk);
    chk("midrst_bit3_low", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_async", tx, 1'b1);
    chk("midrst_busy_async", busy, 1'b0);
    chk("midrst_rd_en", fifo_rd_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{8'h96, -1});
    fq.push_back(8'h96);
    wait_exp(200, "frame_after_rst");
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
